instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Fetch stage directly downstream of the PC register. Issues instruction-memory reads at the current PC.
//  Pulses pc_write (to the PC's PCWrite input) once per accepted fetch.
//  Buffers fetched {pc, instr} pairs in a DEPTH-entry FIFO feeding decode via valid/ready.
//  flush handles branch/exception redirects and discards queued and in-flight fetches.
// PARAMETERS
//  WIDTH  32  address width of pc_addr / imem_addr / id_pc
//  DEPTH  4   queue entries; power of two, 2..16; CW = $clog2(DEPTH+1)
// PORTS
//  clk             input   1      single clock, rising edge
//  rst             input   1      asynchronous, active-low reset (0 = reset)
//  pc_addr         input   WIDTH  current PC from the PC register
//  pc_write        output  1      advance PC; combinational, one cycle per accepted fetch
//  imem_req        output  1      memory read request
//  imem_addr       output  WIDTH  request address (registered addr_q)
//  imem_ack        input   1      memory accepts request and returns imem_rdata this cycle
//  imem_rdata      input   32     instruction word, valid with imem_ack
//  flush           input   1      discard queue and any in-flight fetch
//  id_valid        output  1      queue head valid
//  id_instr        output  32     queue head instruction
//  id_pc           output  WIDTH  queue head PC
//  id_ready        input   1      decode accepts head this cycle
//  count           output  CW     occupied entries
//  fetch_misalign  output  1      sticky misaligned-fetch flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE.
//    - addr_q, count, rd/wr pointers and all storage cleared.
//    - imem_req=0, pc_write=0, id_valid=0, id_instr=0, id_pc=0, fetch_misalign=0.
//  - FSM states IDLE / REQ / DROP:
//    - IDLE: imem_req=0.
//      - If !flush && count<DEPTH: addr_q<=pc_addr, go to REQ.
//    - REQ: imem_req=1, imem_addr=addr_q.
//      - ack && !flush: push {addr_q, imem_rdata}; pc_write=1 that cycle; go to IDLE.
//      - ack && flush: data dropped, pc_write=0, go to IDLE.
//      - !ack && flush: go to DROP.
//      - !ack && !flush: stay in REQ, addr_q held.
//    - DROP: imem_req=1, addr_q held. On ack: data dropped, pc_write=0, go to IDLE.
//      - Any further flush while in DROP is ignored.
//  - Handshake: imem_req, once raised, is never withdrawn before imem_ack; imem_addr is stable throughout.
//  - Throughput: at most 1 fetch per 2 cycles. IDLE->REQ is one cycle; the PC updates on the pc_write edge.
//  - Latency: with ack in the first REQ cycle, the entry is visible at id_* the cycle after ack.
//  - Queue:
//    - pop = id_valid && id_ready; id_* driven combinationally from the head entry.
//    - id_valid = (count != 0).
//    - Push and pop in the same cycle: count unchanged, order preserved.
//    - Pointers wrap modulo DEPTH.
//  - Full: a request is issued only when count<DEPTH and at most one fetch is in flight, so a push can never overflow.
//    - count==DEPTH holds in IDLE with imem_req=0.
//  - Empty: id_valid=0. Pops with id_ready while empty are ignored.
//  - flush has priority over push and pop: count=0 and pointers reset at that edge; id_valid=0 the next cycle.
//  - Reset asserted mid-REQ/DROP: immediate return to IDLE. The memory side must tolerate the dropped request.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined:
//    - On an accepted ack with addr_q[1:0]!=0: the pushed entry has id_instr=32'h0000_0000 (nop), id_pc=addr_q.
//    - pc_write still pulses.
//    - fetch_misalign is set and stays 1 until flush or reset.
//  FETCH_ALIGN_CHECK_EN undefined: no check, imem_rdata always pushed, fetch_misalign tied 0.
// TESTING
//  1. Release reset, pc_addr=0x3000, ack in first REQ cycle with rdata=0x2008_0001, id_ready=1.
//     -> imem_req 1 cycle after reset, pc_write pulses with ack.
//     -> next cycle id_valid=1, id_instr=0x20080001, id_pc=0x3000.
//  2. id_ready=0, zero-wait memory, PC increments by 4.
//     -> entries 0x3000,0x3004,0x3008,0x300C; count=4; imem_req stays 0.
//     -> raise id_ready: drained in order over 4 cycles, then fetching resumes.
//  3. Flush in the first REQ cycle, ack 3 cycles later.
//     -> DROP state, imem_req held, imem_addr unchanged.
//     -> at ack: no pc_write, no push, count=0.
//  4. flush coincident with ack and a pop, count=2.
//     -> next cycle count=0, id_valid=0, pc_write=0 on the ack cycle.
//  5. rst driven low between clock edges while in REQ.
//     -> imem_req, id_valid, count, fetch_misalign go to 0 without a clock edge.
//  6. With FETCH_ALIGN_CHECK_EN, pc_addr=0x3002.
//     -> entry id_instr=0, id_pc=0x3002, fetch_misalign=1 until flush.
//     -> without the macro: id_instr=imem_rdata, fetch_misalign=0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues instruction-memory reads at the current PC and queues {pc, instr} pairs for decode.
// Optional build macro FETCH_ALIGN_CHECK_EN turns misaligned fetches into nops and raises fetch_misalign.
module instr_fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_addr,
    output logic             pc_write,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             flush,
    output logic             id_valid,
    output logic [31:0]      id_instr,
    output logic [WIDTH-1:0] id_pc,
    input  logic             id_ready,
    output logic [CW-1:0]    count,
    output logic             fetch_misalign,
    output logic [1:0]       state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_t;

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  addr_q;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [WIDTH-1:0]  mem_pc    [DEPTH];
    logic [31:0]       mem_instr [DEPTH];
    logic              push;
    logic              pop;
    logic              load_addr;
    logic [31:0]       push_instr;

    // Both interfaces are valid/ready: a transfer happens on the rising edge where
    // imem_req&&imem_ack (memory side) or id_valid&&id_ready (decode side) are both high;
    // the initiator holds its valid and payload stable until that edge.
    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        pc_write   = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && count < FULL) next_state = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    next_state = IDLE;
                    if (!flush) begin
                        push     = 1'b1;
                        pc_write = 1'b1;
                    end
                end else if (flush) begin
                    next_state = DROP;
                end
            end
            DROP: begin
                // The outstanding read must still complete; its data is discarded.
                imem_req = 1'b1;
                if (imem_ack) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign load_addr = (state == IDLE) && (next_state == REQ);
    assign pop       = id_valid && id_ready;
    assign id_valid  = (count != '0);
    assign id_instr  = mem_instr[rd_ptr];
    assign id_pc     = mem_pc[rd_ptr];
    assign imem_addr = addr_q;
    assign state_dbg = state;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    logic misalign_q;
    assign misaligned     = (addr_q[1:0] != 2'b00);
    assign push_instr     = misaligned ? 32'h0000_0000 : imem_rdata;
    assign fetch_misalign = misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else if (flush) begin
            misalign_q <= 1'b0;
        end else if (push && misaligned) begin
            misalign_q <= 1'b1;
        end
    end
`else
    assign push_instr     = imem_rdata;
    assign fetch_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            addr_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else begin
            state <= next_state;
            if (load_addr) addr_q <= pc_addr;
            // Flush wins over any push or pop in the same cycle.
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem_pc[wr_ptr]    <= addr_q;
                    mem_instr[wr_ptr] <= push_instr;
                    wr_ptr            <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_instr_fetch_queue;
    logic        clk;
    logic        rst;
    logic [31:0] pc_addr;
    logic        pc_write;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic [2:0]  count;
    logic        fetch_misalign;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [31:0] EXP_MIS_I = 32'h0000_0000;
    localparam logic        EXP_M     = 1'b1;
`else
    localparam logic [31:0] EXP_MIS_I = 32'h1234_5678;
    localparam logic        EXP_M     = 1'b0;
`endif

    instr_fetch_queue #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_write(pc_write),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .flush(flush), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
        .count(count), .fetch_misalign(fetch_misalign), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic        e_pw;
        logic        e_v;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [31:0] pc, input logic a, input logic [31:0] d,
                       input logic rdy, input logic ereq, input logic epw, input logic ev,
                       input logic [31:0] ei, input logic [31:0] ep, input logic [2:0] ec,
                       input logic [31:0] ea);
        vec_t v;
        v = '{r, pc, a, d, rdy, ereq, epw, ev, ei, ep, ec, ea};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; pc_addr = '0; imem_ack = 0; imem_rdata = '0; flush = 0; id_ready = 0;
        #2 rst = 1'b0;

        //   rst pc          ack rdata         rdy req pw v  instr         pc          cnt addr
        add(0, 32'h3000, 0, 32'h0,        1,  0, 0, 0, 32'h0,        32'h0,    0, 32'h0);
        add(1, 32'h3000, 0, 32'h0,        1,  0, 0, 0, 32'h0,        32'h0,    0, 32'h0);
        add(1, 32'h3000, 1, 32'h20080001, 1,  1, 1, 0, 32'h0,        32'h0,    0, 32'h3000);
        add(1, 32'h3004, 0, 32'h0,        1,  0, 0, 1, 32'h20080001, 32'h3000, 1, 32'h0);
        add(0, 32'h3004, 0, 32'h0,        0,  0, 0, 0, 32'h0,        32'h0,    0, 32'h0);
        add(1, 32'h3000, 0, 32'h0,        0,  0, 0, 0, 32'h0,        32'h0,    0, 32'h0);
        add(1, 32'h3000, 1, 32'h11110000, 0,  1, 1, 0, 32'h0,        32'h0,    0, 32'h3000);
        add(1, 32'h3004, 0, 32'h0,        0,  0, 0, 1, 32'h11110000, 32'h3000, 1, 32'h0);
        add(1, 32'h3004, 1, 32'h11110004, 0,  1, 1, 1, 32'h11110000, 32'h3000, 1, 32'h3004);
        add(1, 32'h3008, 0, 32'h0,        0,  0, 0, 1, 32'h11110000, 32'h3000, 2, 32'h0);
        add(1, 32'h3008, 1, 32'h11110008, 0,  1, 1, 1, 32'h11110000, 32'h3000, 2, 32'h3008);
        add(1, 32'h300C, 0, 32'h0,        0,  0, 0, 1, 32'h11110000, 32'h3000, 3, 32'h0);
        add(1, 32'h300C, 1, 32'h1111000C, 0,  1, 1, 1, 32'h11110000, 32'h3000, 3, 32'h300C);
        add(1, 32'h3010, 0, 32'h0,        0,  0, 0, 1, 32'h11110000, 32'h3000, 4, 32'h0);
        add(1, 32'h3010, 0, 32'h0,        0,  0, 0, 1, 32'h11110000, 32'h3000, 4, 32'h0);
        add(1, 32'h3010, 0, 32'h0,        1,  0, 0, 1, 32'h11110000, 32'h3000, 4, 32'h0);
        add(1, 32'h3010, 0, 32'h0,        1,  0, 0, 1, 32'h11110004, 32'h3004, 3, 32'h0);
        add(1, 32'h3010, 0, 32'h0,        1,  1, 0, 1, 32'h11110008, 32'h3008, 2, 32'h3010);
        add(1, 32'h3010, 0, 32'h0,        1,  1, 0, 1, 32'h1111000C, 32'h300C, 1, 32'h3010);
        add(1, 32'h3010, 1, 32'h11110010, 1,  1, 1, 0, 32'h0,        32'h0,    0, 32'h3010);
        add(1, 32'h3014, 0, 32'h0,        0,  0, 0, 1, 32'h11110010, 32'h3010, 1, 32'h0);

        step();
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; pc_addr = vecs[i].pc; imem_ack = vecs[i].ack;
            imem_rdata = vecs[i].rdata; id_ready = vecs[i].ready; flush = 0;
            mid();
            chk($sformatf("v%0d.imem_req", i), imem_req, vecs[i].e_req);
            chk($sformatf("v%0d.pc_write", i), pc_write, vecs[i].e_pw);
            chk($sformatf("v%0d.id_valid", i), id_valid, vecs[i].e_v);
            chk($sformatf("v%0d.count", i), count, vecs[i].e_cnt);
            if (vecs[i].e_v || !vecs[i].rst) begin
                chk($sformatf("v%0d.id_instr", i), id_instr, vecs[i].e_instr);
                chk($sformatf("v%0d.id_pc", i), id_pc, vecs[i].e_pc);
            end
            if (vecs[i].e_req) chk($sformatf("v%0d.imem_addr", i), imem_addr, vecs[i].e_addr);
            if (!vecs[i].rst) chk($sformatf("v%0d.misalign", i), fetch_misalign, 0);
            step();
        end

        // flush in first REQ cycle, ack arrives three cycles later
        rst = 0; imem_ack = 0; flush = 0; id_ready = 0; pc_addr = 32'h4000;
        step(); rst = 1;
        mid(); chk("t3.idle_req", imem_req, 0); step();
        flush = 1;
        mid(); chk("t3.req", imem_req, 1); chk("t3.addr", imem_addr, 32'h4000); step();
        flush = 0; pc_addr = 32'h5000;
        mid(); chk("t3.drop_req1", imem_req, 1); chk("t3.drop_addr1", imem_addr, 32'h4000); step();
        flush = 1;
        mid(); chk("t3.drop_req2", imem_req, 1); chk("t3.drop_addr2", imem_addr, 32'h4000); step();
        flush = 0; imem_ack = 1; imem_rdata = 32'hDEADBEEF;
        mid(); chk("t3.ack_req", imem_req, 1); chk("t3.ack_pw", pc_write, 0); step();
        imem_ack = 0;
        mid(); chk("t3.count", count, 0); chk("t3.valid", id_valid, 0); chk("t3.idle", imem_req, 0);
        step();

        // flush coincident with ack and pop while two entries are queued
        imem_ack = 1; imem_rdata = 32'hA000_0000; exp_q.push_back(32'hA000_0000);
        mid(); chk("t4.pw0", pc_write, 1); chk("t4.addr0", imem_addr, 32'h5000); step();
        imem_ack = 0; pc_addr = 32'h5004;
        mid(); chk("t4.head0", id_instr, exp_q[0]); step();
        imem_ack = 1; imem_rdata = 32'hA000_0001; exp_q.push_back(32'hA000_0001);
        mid(); chk("t4.pw1", pc_write, 1); step();
        imem_ack = 0; pc_addr = 32'h5008;
        mid(); chk("t4.count2", count, 2); step();
        imem_ack = 1; imem_rdata = 32'hA000_0002; flush = 1; id_ready = 1;
        mid();
        chk("t4.flush_pw", pc_write, 0); chk("t4.flush_cnt", count, 2);
        chk("t4.flush_head", id_instr, exp_q[0]); chk("t4.flush_pc", id_pc, 32'h5000);
        step();
        exp_q.delete();
        imem_ack = 0; flush = 0; id_ready = 0; pc_addr = 32'h3002;
        mid(); chk("t4.after_cnt", count, 0); chk("t4.after_valid", id_valid, 0); step();

        // misaligned fetch, then asynchronous reset between edges while in REQ
        imem_ack = 1; imem_rdata = 32'h1234_5678;
        mid(); chk("t6.pw", pc_write, 1); chk("t6.addr", imem_addr, 32'h3002); step();
        imem_ack = 0; pc_addr = 32'h3008;
        mid();
        chk("t6.valid", id_valid, 1); chk("t6.id_pc", id_pc, 32'h3002);
        chk("t6.id_instr", id_instr, EXP_MIS_I); chk("t6.misalign", fetch_misalign, EXP_M);
        step();
        mid();
        chk("t5.pre_req", imem_req, 1); chk("t5.pre_cnt", count, 1);
        chk("t6.sticky", fetch_misalign, EXP_M);
        #2 rst = 0;
        #1;
        chk("t5.req", imem_req, 0); chk("t5.valid", id_valid, 0);
        chk("t5.count", count, 0); chk("t5.misalign", fetch_misalign, 0);
        step(); rst = 1; pc_addr = 32'h3002;
        mid(); step();
        imem_ack = 1; imem_rdata = 32'hCAFE_0001;
        mid(); step();
        imem_ack = 0; pc_addr = 32'h300C;
        mid(); chk("t6.set_again", fetch_misalign, EXP_M); step();
        imem_ack = 1; flush = 1;
        mid(); chk("t6.flush_pw", pc_write, 0); step();
        imem_ack = 0; flush = 0;
        mid();
        chk("t6.cleared", fetch_misalign, 0); chk("t6.cnt", count, 0); chk("t6.valid0", id_valid, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
